// File: rtl/key_iv_load_if.sv
// Handshake bundle between the key/IV load controller and its serial source, shift register, engine and keystream consumer.
// done_o exists only when KS_LIMIT_EN is defined.
interface key_iv_load_if;
    logic start_i;
    logic abort_i;
    logic ser_dat_i;
    logic ser_vld_i;
    logic sr_ce_o;
    logic sr_dat_o;
    logic load_o;
    logic eng_ce_o;
    logic ks_req_i;
    logic ks_vld_o;
    logic busy_o;
    logic ready_o;
`ifdef KS_LIMIT_EN
    logic done_o;
`endif

    // Controller side.
    modport slave (
        input  start_i,
        input  abort_i,
        input  ser_dat_i,
        input  ser_vld_i,
        input  ks_req_i,
`ifdef KS_LIMIT_EN
        output done_o,
`endif
        output sr_ce_o,
        output sr_dat_o,
        output load_o,
        output eng_ce_o,
        output ks_vld_o,
        output busy_o,
        output ready_o
    );

    // Source/consumer side.
    modport master (
        output start_i,
        output abort_i,
        output ser_dat_i,
        output ser_vld_i,
        output ks_req_i,
`ifdef KS_LIMIT_EN
        input  done_o,
`endif
        input  sr_ce_o,
        input  sr_dat_o,
        input  load_o,
        input  eng_ce_o,
        input  ks_vld_o,
        input  busy_o,
        input  ready_o
    );
endinterface

// File: rtl/key_iv_load_ctrl.sv
// Trivium key/IV load control: gates serial key/IV into the shift register, pulses load, warms up, grants keystream (KS_LIMIT_EN adds a bit limit + done_o).
// Latency: sr_ce_o/sr_dat_o/eng_ce_o/ks_vld_o combinational; load_o the cycle after the last bit; RUN after WARMUP_CYC enables.
// Backpressure: ser_vld_i gaps stall the bit count; ks_req_i gates each keystream bit; abort_i overrides everything.
module key_iv_load_ctrl #(
    parameter int KEY_IV_BITS = 160,
    parameter int WARMUP_CYC  = 1152,
    parameter int CNT_W       = 11,
    parameter int KS_MAX_BITS = 1024
) (
    input  logic          clk_i,
    input  logic          n_rst_i,
    key_iv_load_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        LOAD   = 3'd2,
        WARMUP = 3'd3,
        RUN    = 3'd4
    } state_t;

    localparam int CNT_NEED = (KEY_IV_BITS > WARMUP_CYC) ? KEY_IV_BITS : WARMUP_CYC;

    // The shared counter must hold every terminal value without wrapping.
    generate
        if ((CNT_NEED >= (1 << CNT_W)) || (KS_MAX_BITS > (1 << CNT_W)) ||
            (KEY_IV_BITS < 1) || (WARMUP_CYC < 1) || (KS_MAX_BITS < 1)) begin : g_param_check
            $error("key_iv_load_ctrl: CNT_W too small for KEY_IV_BITS/WARMUP_CYC/KS_MAX_BITS");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(KEY_IV_BITS - 1);
    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sr_ce, sr_dat, eng_ce, ks_vld;
`ifdef KS_LIMIT_EN
    localparam logic [CNT_W-1:0] KS_LAST = CNT_W'(KS_MAX_BITS - 1);
    logic             done_q, done_d;
`endif

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_ce   = 1'b0;
        sr_dat  = 1'b0;
        eng_ce  = 1'b0;
        ks_vld  = 1'b0;
`ifdef KS_LIMIT_EN
        done_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                sr_ce  = bus.ser_vld_i;
                sr_dat = bus.ser_dat_i;
                if (bus.ser_vld_i) begin
                    if (cnt_q == SHIFT_LAST) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                state_d = WARMUP;
                cnt_d   = '0;
            end
            WARMUP: begin
                eng_ce = 1'b1;
                if (cnt_q == WARMUP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                eng_ce = bus.ks_req_i;
                ks_vld = bus.ks_req_i;
`ifdef KS_LIMIT_EN
                // The bit granted on the terminal count is still delivered.
                if (bus.ks_req_i) begin
                    if (cnt_q == KS_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort wins over every transition and silences the combinational enables.
        if (bus.abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_ce   = 1'b0;
            eng_ce  = 1'b0;
            ks_vld  = 1'b0;
`ifdef KS_LIMIT_EN
            done_d  = 1'b0;
`endif
        end
    end

`ifdef KS_LIMIT_EN
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign bus.done_o = done_q;
`endif

    assign bus.sr_ce_o  = sr_ce;
    assign bus.sr_dat_o = sr_dat;
    assign bus.eng_ce_o = eng_ce;
    assign bus.ks_vld_o = ks_vld;
    assign bus.load_o   = (state_q == LOAD);
    assign bus.busy_o   = (state_q != IDLE);
    assign bus.ready_o  = (state_q == RUN);

endmodule

// File: doc/key_iv_load_ctrl.md
Name: key_iv_load_ctrl

Overview:
- Control stage directly upstream of the 160-bit key/IV serial shift register.
- Accepts a serial key/IV bit stream (IV first, LSB first) and gates that bit stream into the shift register.
- Counts the bits; once all KEY_IV_BITS bits are in, pulses a parallel load into the Trivium cipher engine.
- Then runs the mandatory warm-up, and after that enables keystream generation on request.

Parameters:
- KEY_IV_BITS, 160, number of serial bits that make up the key plus IV.
- WARMUP_CYC, 1152, number of engine clock-enable cycles discarded after load (4×288).
- CNT_W, 11, width of the shared counter; must satisfy 2^CNT_W > max(KEY_IV_BITS, WARMUP_CYC).
- KS_MAX_BITS, 1024, keystream bit limit; used only with KS_LIMIT_EN.

Ports:
- clk_i  input  1  system clock.
- n_rst_i  input  1  asynchronous active-low reset.
- start_i  input  1  begin a new key/IV load; sampled only in IDLE.
- abort_i  input  1  synchronous abort from any state.
- ser_dat_i  input  1  serial key/IV bit.
- ser_vld_i  input  1  ser_dat_i is valid this cycle.
- sr_ce_o  output  1  shift-register clock enable.
- sr_dat_o  output  1  shift-register serial data.
- load_o  output  1  one-cycle pulse: engine loads key/IV from the shift register.
- eng_ce_o  output  1  cipher engine clock enable.
- ks_req_i  input  1  consumer requests one keystream bit.
- ks_vld_o  output  1  the engine output bit this cycle is valid keystream.
- busy_o  output  1  high in every state except IDLE.
- ready_o  output  1  high in RUN (warm-up complete).
- done_o  output  1  one-cycle pulse on limit reached; only with KS_LIMIT_EN, otherwise the port is absent.

Behaviour:
- Reset and clocking:
  - Clock is clk_i; reset is n_rst_i, asynchronous, active-low.
  - Reset forces state IDLE and counter 0. All registered outputs are 0 during reset: load_o, busy_o, ready_o, done_o.
- FSM states: IDLE, SHIFT, LOAD, WARMUP, RUN. One counter cnt[CNT_W-1:0] is shared by SHIFT, WARMUP and RUN.
- IDLE:
  - start_i=1 -> SHIFT, cnt<=0.
  - start_i outside IDLE is ignored.
- SHIFT:
  - sr_ce_o = ser_vld_i; sr_dat_o = ser_dat_i. Both are combinational, zero latency.
  - Each cycle with ser_vld_i=1 increments cnt.
  - When ser_vld_i=1 and cnt==KEY_IV_BITS-1, that bit is the last one; transition to LOAD and clear cnt.
  - Gaps in ser_vld_i are allowed and stall the count.
- LOAD:
  - load_o=1 for exactly one cycle, then -> WARMUP.
  - sr_ce_o=0 here; the shift register content is stable.
- WARMUP:
  - eng_ce_o=1 every cycle; cnt increments.
  - At cnt==WARMUP_CYC-1 -> RUN and clear cnt. This gives exactly WARMUP_CYC enable cycles.
  - ks_vld_o=0 throughout.
- RUN:
  - ready_o=1.
  - eng_ce_o = ks_req_i and ks_vld_o = ks_req_i, both combinational.
  - Stays in RUN until abort_i (or the limit, see Optional Feature).
- sr_ce_o, eng_ce_o and ks_vld_o are 0 in every state other than those listed above.
- abort_i:
  - From any state, the next state is IDLE and cnt<=0.
  - abort_i has priority over every other transition, including simultaneous start_i in IDLE and the final SHIFT bit.
  - In the abort cycle itself, the combinational outputs are forced to 0: sr_ce_o, eng_ce_o, ks_vld_o.
- Reset mid-operation: returns to IDLE immediately; no load_o pulse is produced.
- Counter: it never wraps in legal operation. The parameter check (CNT_W constraint) is a synthesis-time assertion.

Optional Feature:
- Macro: KS_LIMIT_EN.
- When defined:
  - In RUN, cnt counts granted keystream bits (ks_req_i=1).
  - On the grant where cnt==KS_MAX_BITS-1, that bit is still valid. The next state is IDLE, and done_o pulses 1 for one cycle, registered, in the first IDLE cycle.
  - abort_i in the same cycle wins: no done_o.
- When undefined:
  - The done_o port and the limit logic are omitted.
  - RUN is left only via abort_i or reset.

Test Plan:
- Basic load: reset, start_i=1, 160 contiguous ser_vld_i bits of pattern 0xA5 repeated -> sr_ce_o high for exactly 160 cycles, sr_dat_o mirrors ser_dat_i, load_o high on exactly one cycle right after the 160th bit.
- Gapped input: ser_vld_i toggling 1/0 for 320 cycles -> load_o occurs only after the 160th valid bit (cycle 320 after SHIFT entry), sr_ce_o count = 160.
- Warm-up length: after load_o -> eng_ce_o high for exactly 1152 consecutive cycles, ks_vld_o=0 throughout, ready_o rises on cycle 1153.
- Keystream grant: in RUN, ks_req_i = 1,0,1,1 -> eng_ce_o and ks_vld_o = 1,0,1,1 in the same cycles.
- Abort: abort_i at bit 80 of SHIFT -> next cycle IDLE, busy_o=0, no load_o. A new start_i then requires a full 160 bits.
- KS_LIMIT_EN with KS_MAX_BITS=8: 8 grants -> state IDLE, done_o single pulse, ready_o=0. Repeat with abort_i coincident with the 8th grant -> no done_o.
